// File: rtl/split_ctrl.sv
// split_ctrl: registered master-to-N-slave splitter with slave lock; define SPLIT_CTRL_TIMEOUT_EN to abort silent slaves
module split_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int N_SLAVES = 4,
  parameter int P_SLAVES = ADDR_W - 1,
  parameter int TIMEOUT = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
  localparam int REQ_W = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W = DATA_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_W-1:0]             m_req,
  output logic [RESP_W-1:0]            m_resp,
  output logic [N_SLAVES*REQ_W-1:0]    s_req,
  input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
  output logic                         err
);
  localparam int NB = $clog2(N_SLAVES);
  localparam int SEL_MSB = DATA_W + DATA_W / 8 + P_SLAVES;
  localparam logic [DATA_W-1:0] ERR_D = DATA_W'(ERR_DATA);
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t state;
  logic [NB-1:0] sel, sel_r, cur;
  logic valid, mapped, drive, rdy, tmo;
  assign valid = m_req[REQ_W-1];
  assign sel = m_req[SEL_MSB -: NB];
  assign mapped = int'(sel) < N_SLAVES;
  assign cur = state == BUSY ? sel_r : sel;
  assign drive = !rst && (state == BUSY || (state == IDLE && valid && mapped));
`ifdef SPLIT_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo = state == BUSY && cnt == CW'(TIMEOUT);
  // wait counter: cleared outside BUSY, counts silent BUSY cycles and saturates at TIMEOUT
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (state != BUSY) cnt <= '0;
    else if (!rdy && !tmo) cnt <= cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  // route the request to the selected slave and pass only a ready response back
  always_comb begin
    s_req = '0;
    m_resp = '0;
    rdy = 1'b0;
    for (int i = 0; i < N_SLAVES; i++)
      if (drive && cur == NB'(i)) begin
        s_req[i*REQ_W +: REQ_W] = {valid & ~tmo, m_req[REQ_W-2:0]};
        rdy = s_resp[i*RESP_W];
        m_resp = rdy ? s_resp[i*RESP_W +: RESP_W] : '0;
      end
    if (!rst && state == ERR) m_resp = {ERR_D, 1'b1};
  end
  // transaction FSM: lock the slave while busy, one-cycle error pulse on unmapped or timed-out access
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sel_r <= '0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE:
          if (valid && mapped) begin
            sel_r <= sel;
            state <= rdy ? IDLE : BUSY;
          end else if (valid) begin
            state <= ERR;
            err <= 1'b1;
          end
        BUSY:
          if (rdy) state <= IDLE;
          else if (tmo) begin
            state <= ERR;
            err <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_split_ctrl.sv
// tb_split_ctrl: randomized scoreboard bench for split_ctrl
module tb_split_ctrl;
  localparam int DW = 32, AW = 16, N = 3, TO = 8;
  localparam int REQ_W = 1 + AW + DW + DW / 8, RESP_W = DW + 1;
`ifdef SPLIT_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [REQ_W-1:0] m_req = '0;
  logic [RESP_W-1:0] m_resp;
  logic [N*REQ_W-1:0] s_req;
  logic [N*RESP_W-1:0] s_resp = '0;
  logic err;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {logic [DW-1:0] data; logic e; int at;} exp_t;
  exp_t q[$];

  split_ctrl #(.DATA_W(DW), .ADDR_W(AW), .N_SLAVES(N), .P_SLAVES(AW-1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp),
    .s_req(s_req), .s_resp(s_resp), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: every ready response is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      if (m_resp[0]) begin
        if (q.size() == 0) chk("resp_unexpected", m_resp, '0);
        else begin
          x = q.pop_front();
          chk("rdata", m_resp[RESP_W-1:1], x.data);
          chk("err", err, x.e);
          chk("latency", cyc, x.at);
        end
      end else chk("idle_zero", {m_resp, err}, '0);
    end
  end

  task automatic noise();
    for (int i = 0; i < N; i++) s_resp[i*RESP_W +: RESP_W] = {DW'($urandom), 1'($urandom)};
  endtask

  // one transaction: slave sel answers L cycles after valid; chg moves the address while waiting
  task automatic do_txn(input int sel, input int L, input bit chg, input logic [DW-1:0] rd);
    bit mapped, is_to;
    int lat;
    exp_t x;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0] ws;
    logic [REQ_W-1:0] e;
    mapped = sel < N;
    is_to = mapped && TO_EN && L > TO + 1;
    lat = !mapped ? 1 : is_to ? TO + 2 : L;
    x.data = (mapped && !is_to) ? rd : 32'hDEADBEEF;
    x.e = !mapped || is_to;
    x.at = cyc + lat;
    q.push_back(x);
    a = {2'(sel), 14'($urandom)};
    wd = $urandom;
    ws = 4'($urandom);
    for (int k = 0; k <= lat; k++) begin
      if (chg && k >= 1) a[AW-1 -: 2] = 2'(sel + 1);
      m_req = {1'b1, a, wd, ws};
      for (int i = 0; i < N; i++)
        s_resp[i*RESP_W +: RESP_W] = (mapped && i == sel) ? {(k == L) ? rd : DW'($urandom), k == L}
                                                          : {DW'($urandom), 1'($urandom)};
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        e = (mapped && i == sel && !(is_to && k == lat)) ? {!(TO_EN && k == TO + 1), m_req[REQ_W-2:0]} : '0;
        chk($sformatf("s_req%0d", i), s_req[i*REQ_W +: REQ_W], e);
      end
      @(posedge clk); #1;
    end
    m_req = '0;
    repeat ($urandom_range(1, 2)) begin
      noise();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    m_req = {1'b1, 2'd1, 14'h0, 32'h0, 4'hf};
    s_resp = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sreq", s_req, '0);
    chk("rst_mresp", {m_resp, err}, '0);
    m_req = '0;
    s_resp = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    do_txn(2, 0, 0, 32'h1234);
    do_txn(1, 5, 1, 32'hCAFE_0001);
    do_txn(3, 0, 0, 32'h0);
    do_txn(0, 20, 0, 32'h5555_AAAA);
    do_txn(2, TO + 1, 0, 32'h0BAD_F00D);
    do_txn(1, TO, 1, 32'h7777_0000);
    m_req = {1'b1, 2'd1, 14'h12, 32'h0, 4'hf};
    s_resp = '0;
    @(posedge clk); #1;
    chk("busy_fwd", s_req[REQ_W + REQ_W - 1], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_sreq", s_req, '0);
    chk("rst_busy_mresp", {m_resp, err}, '0);
    @(posedge clk); #1;
    m_req = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    do_txn(0, 3, 0, 32'h0000_0A0A);
    for (int t = 0; t < 80; t++)
      do_txn($urandom_range(0, 3), $urandom_range(0, 12), 1'($urandom), $urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/split_ctrl.md
# split_ctrl

Registered successor to the combinational address splitter. It routes one native-interface master to `N_SLAVES` slaves, selected by an address field. The selected slave is locked for the whole transaction, so the response path cannot glitch if the master's address changes mid-transfer. Unmapped accesses and slaves that never answer are terminated with an error response, so the master never hangs. It sits between a CPU or bus master and the peripheral/memory slave ports.

## Interface
Parameters:
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: address width.
- `N_SLAVES`, 4: slave count, ≥2; `NB = $clog2(N_SLAVES)`.
- `P_SLAVES`, `ADDR_W-1`: MSB position of the slave-select field inside the address. The field is `addr[P_SLAVES -: NB]`.
- `TIMEOUT`, 256: maximum wait cycles before the access is aborted. Applies only with `SPLIT_CTRL_TIMEOUT_EN`.
- `ERR_DATA`, `32'hDEADBEEF`: `rdata` returned on an error, truncated or zero-extended to `DATA_W`.

Ports (`REQ_W = 1+ADDR_W+DATA_W+DATA_W/8`, layout `{valid, addr, wdata, wstrb}`; `RESP_W = DATA_W+1`, layout `{rdata, ready}`):
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `m_req`, in, `REQ_W`: master request.
- `m_resp`, out, `RESP_W`: master response.
- `s_req`, out, `N_SLAVES*REQ_W`: slave requests; slave i occupies slice i.
- `s_resp`, in, `N_SLAVES*RESP_W`: slave responses; slave i occupies slice i.
- `err`, out, 1: one-cycle pulse, coincident with an error response.

## Operation
- FSM states: IDLE, BUSY, ERR.
- IDLE:
  - `sel = addr[P_SLAVES -: NB]`.
  - If `valid` is set and `sel < N_SLAVES`, `m_req` is forwarded combinationally to slave `sel` in the same cycle, and `sel_r <= sel`.
  - If that slave's `ready` is already 1 this cycle, its response passes to `m_resp` and the FSM stays in IDLE. Otherwise the FSM moves to BUSY and the wait counter clears.
- IDLE, `valid` set and `sel >= N_SLAVES`: no slave is driven; the FSM moves to ERR.
- BUSY:
  - `m_req` is forwarded to slave `sel_r`, regardless of the current address.
  - `m_resp = s_resp[sel_r]`.
  - When `ready` = 1, the FSM returns to IDLE.
- ERR: `m_resp = {ERR_DATA, 1'b1}` and `err = 1` for exactly one cycle, then IDLE.
- All non-selected `s_req` slices are zero. When no response is being driven, `m_resp` is zero.
- The master holds `valid` and its request stable until it sees `ready`, and drops `valid` in the cycle after `ready`. One transaction is outstanding at a time.
- A `ready` from a non-selected slave is ignored.

## Timing
- Reset (asynchronous): state IDLE, `sel_r = 0`, counter 0, `err = 0`. While `rst` is high, `s_req` and `m_resp` are forced to all-zero. A reset during BUSY abandons the transaction silently, with no error response.
- Request path is zero latency (combinational). Response latency equals the slave latency, with no added cycle.
- Error latency:
  - Unmapped address: `ready` arrives 1 cycle after `valid`.
  - Timeout: `ready` arrives `TIMEOUT+1` cycles after entry to BUSY.
- Counter width is `$clog2(TIMEOUT+1)` and saturates, with no wrap.
- If a slave's `ready` and the timeout fire in the same cycle, the slave response wins and no error is raised.

## Configuration
- `SPLIT_CTRL_TIMEOUT_EN` defined:
  - In BUSY the counter increments every cycle without `ready`.
  - On reaching `TIMEOUT`, the slave's `valid` is deasserted in that same cycle and the FSM moves to ERR.
- Undefined: no counter logic is built, and BUSY waits indefinitely for the slave's `ready`. Unmapped-address errors still apply.

## Test plan
- Zero-wait access: `N_SLAVES`=4, read with address select field 2; slave 2 returns `ready`=1 in the same cycle with `rdata`=0x1234 → `m_resp` = {0x1234, 1} that cycle; other `s_req` slices are 0; FSM stays in IDLE.
- Multi-cycle access with address change: slave 1 responds after 5 cycles; master changes `addr` to select slave 3 in cycle 2 → slave 3 never sees `valid`, and the response comes from slave 1.
- Unmapped address: `N_SLAVES`=3, select field 3 → next cycle `m_resp` = {0xDEADBEEF, 1} and `err`=1 for 1 cycle; no slave `valid` is asserted.
- Timeout (`SPLIT_CTRL_TIMEOUT_EN`, `TIMEOUT`=8): selected slave is silent → its `valid` drops after 8 BUSY cycles; error response and `err` pulse the next cycle.
- Timeout and `ready` together: slave `ready` arrives exactly on cycle 8 → normal response, `err`=0.
- Reset mid-BUSY: assert `rst` in BUSY → all outputs 0 immediately (asynchronous); after release, a new access to slave 0 completes normally.
